// File: rtl/clock_step_unit_pkg.sv
// Shared definitions for the CPU clock generator: state encoding and default timing.
package clock_step_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN_LO  = 3'd1,
    ST_RUN_HI  = 3'd2,
    ST_STEP_HI = 3'd3,
    ST_HALTED  = 3'd4
  } state_t;

  localparam int DEF_DIV_HALF = 16777216;
  localparam int DEF_DEB_CNT  = 1000000;

  // cpu_clk is high exactly in these two states
  function automatic logic is_high(input state_t s);
    return (s == ST_RUN_HI) || (s == ST_STEP_HI);
  endfunction

endpackage

// File: rtl/clock_step_unit_if.sv
// Control inputs and clock outputs of the CPU clock generator.
interface clock_step_unit_if;
  logic       run_sw;
  logic       step_btn;
  logic       halt;
  logic       clr;
  logic       cpu_clk;
  logic       cpu_tick;
  logic [2:0] state_o;
  logic [7:0] step_count;

  modport master (
    output run_sw, step_btn, halt, clr,
    input  cpu_clk, cpu_tick, state_o, step_count
  );

  modport slave (
    input  run_sw, step_btn, halt, clr,
    output cpu_clk, cpu_tick, state_o, step_count
  );
endinterface

// File: rtl/clock_step_unit_debouncer.sv
// Two-flop synchronizer followed by a stability counter for one raw board input.
module debouncer #(
  parameter int DEB_CNT = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);
  localparam int CW = $clog2(DEB_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CNT - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;
  logic [CW-1:0] cnt_reg;

  // The counter runs only while the synchronized input disagrees with the output;
  // any return to agreement restarts the stability window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      level_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      if (sync2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        level_reg <= sync2_reg;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign level = level_reg;
endmodule

// File: rtl/clock_step_unit.sv
// CPU clock generator: free-run divider, debounced single-step and stop on HLT.
module clock_step_unit
  import clock_step_pkg::*;
#(
  parameter int DIV_HALF = DEF_DIV_HALF,
  parameter int DEB_CNT  = DEF_DEB_CNT
) (
  input logic               clk,
  input logic               rst,
  clock_step_unit_if.slave  bus
);
  localparam int PW = $clog2(DIV_HALF);
  localparam logic [PW-1:0] PHASE_LAST = PW'(DIV_HALF - 1);

  logic [1:0] raw;
  logic [1:0] level;

  assign raw = {bus.step_btn, bus.run_sw};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_deb
      debouncer #(.DEB_CNT(DEB_CNT)) u_deb (
        .clk   (clk),
        .rst   (rst),
        .raw   (raw[gi]),
        .level (level[gi])
      );
    end
  endgenerate

  state_t        state_reg, state_next;
  logic [PW-1:0] phase_reg;
  logic          halt_pend_reg, halt_pend_next;
  logic          step_prev_reg;
  logic          cpu_clk_reg;
  logic          cpu_tick_reg;
  logic [7:0]    step_count_reg;

  logic run_db;
  logic step_req;
  logic phase_last;
  logic halt_any;
  logic rising;

  assign run_db     = level[0];
  assign step_req   = level[1] & ~step_prev_reg;
  assign phase_last = (phase_reg == PHASE_LAST);
  // halt seen at any point of a high phase is remembered until that phase ends
  assign halt_any   = bus.halt | halt_pend_reg;
  assign rising     = is_high(state_next) & ~is_high(state_reg);

  always_comb begin
    state_next     = state_reg;
    halt_pend_next = halt_pend_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (bus.halt)      state_next = ST_HALTED;
        else if (run_db)   state_next = ST_RUN_LO;
        else if (step_req) state_next = ST_STEP_HI;
      end
      ST_RUN_LO: begin
        if (bus.halt)        state_next = ST_HALTED;
        else if (!run_db)    state_next = ST_IDLE;
        else if (phase_last) state_next = ST_RUN_HI;
      end
      ST_RUN_HI: begin
        if (phase_last) begin
          if (halt_any)     state_next = ST_HALTED;
          else if (!run_db) state_next = ST_IDLE;
          else              state_next = ST_RUN_LO;
        end
      end
      ST_STEP_HI: begin
        if (phase_last) state_next = halt_any ? ST_HALTED : ST_IDLE;
      end
      ST_HALTED: begin
        if (bus.clr) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (state_next != state_reg)
      halt_pend_next = 1'b0;
    else if (is_high(state_reg) && bus.halt)
      halt_pend_next = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      phase_reg      <= '0;
      halt_pend_reg  <= 1'b0;
      step_prev_reg  <= 1'b0;
      cpu_clk_reg    <= 1'b0;
      cpu_tick_reg   <= 1'b0;
      step_count_reg <= 8'd0;
    end else begin
      state_reg     <= state_next;
      halt_pend_reg <= halt_pend_next;
      step_prev_reg <= level[1];
      if (state_next != state_reg)
        phase_reg <= '0;
      else if (state_reg == ST_RUN_LO || is_high(state_reg))
        phase_reg <= phase_reg + PW'(1);
      cpu_clk_reg  <= is_high(state_next);
      cpu_tick_reg <= rising;
      if (bus.clr)
        step_count_reg <= 8'd0;
      else if (rising)
        step_count_reg <= step_count_reg + 8'd1;
    end
  end

  assign bus.cpu_clk    = cpu_clk_reg;
  assign bus.cpu_tick   = cpu_tick_reg;
  assign bus.state_o    = state_reg;
  assign bus.step_count = step_count_reg;
endmodule

// File: tb/tb_clock_step_unit.sv
// Randomized scoreboard bench for clock_step_unit with DIV_HALF=4, DEB_CNT=3.
`timescale 1ns/1ps
module tb_clock_step_unit;
  localparam int DIV_HALF = 4;
  localparam int DEB_CNT  = 3;
  // raw change after edge k: debounced level at edge k+2+DEB_CNT, FSM reacts one edge later
  localparam int REACT = 2 + DEB_CNT + 1;

  typedef struct {
    int c;
    int n;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   exp_count = 0;
  int   hi_len = 0;
  exp_t q[$];
  exp_t e;

  clock_step_unit_if bus();

  clock_step_unit #(.DIV_HALF(DIV_HALF), .DEB_CNT(DEB_CNT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, expv);
    end
  endtask

  task automatic wait_to(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic push_tick(input int at);
    exp_count = (exp_count + 1) % 256;
    q.push_back('{at, exp_count});
  endtask

  // Monitor: every cpu_tick pops one expected edge; every high pulse must be DIV_HALF long
  always @(negedge clk) begin
    if (rst) begin
      hi_len = 0;
    end else begin
      if (bus.cpu_tick) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tick cycle=%0d actual=1 expected=0", cyc);
        end else begin
          e = q.pop_front();
          chk("tick_cycle", cyc, e.c);
          chk("tick_count", int'(bus.step_count), e.n);
          chk("tick_clk", int'(bus.cpu_clk), 1);
        end
      end
      if (bus.cpu_clk) hi_len++;
      else if (hi_len != 0) begin
        chk("high_width", hi_len, DIV_HALF);
        hi_len = 0;
      end
      $display("cycle=%0d state=%0d cpu_clk=%0d tick=%0d count=%0d",
               cyc, bus.state_o, bus.cpu_clk, bus.cpu_tick, bus.step_count);
    end
  end

  task automatic step_press(input int len);
    int k;
    repeat ($urandom_range(0, 5)) @(negedge clk);
    k = cyc;
    bus.step_btn = 1'b1;
    if (len >= DEB_CNT) push_tick(k + REACT);
    wait_to(k + len);
    bus.step_btn = 1'b0;
    wait_to((k + len + REACT > k + REACT + DIV_HALF + 1) ? k + len + REACT : k + REACT + DIV_HALF + 1);
    chk("step_idle_state", int'(bus.state_o), 0);
  endtask

  // Run for roughly p periods, then drop run_sw at offset off (0..7) relative to a high phase
  task automatic run_burst(input int p, input int off);
    int k, n, r0, d;
    k = cyc;
    bus.run_sw = 1'b1;
    n  = k + REACT;
    r0 = n + DIV_HALF;
    d  = r0 + 2 * DIV_HALF * p - (REACT - 1) + off;
    for (int r = r0; r <= d + REACT - 1; r += 2 * DIV_HALF) push_tick(r);
    wait_to(n - 1);
    chk("pre_run_state", int'(bus.state_o), 0);
    wait_to(n);
    chk("run_lo_state", int'(bus.state_o), 1);
    chk("run_lo_clk", int'(bus.cpu_clk), 0);
    wait_to(d);
    bus.run_sw = 1'b0;
    wait_to(d + REACT + 2 * DIV_HALF);
    chk("run_stop_state", int'(bus.state_o), 0);
    chk("run_stop_clk", int'(bus.cpu_clk), 0);
  endtask

  task automatic clr_pulse();
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    exp_count = 0;
    chk("clr_state", int'(bus.state_o), 0);
    chk("clr_count", int'(bus.step_count), 0);
  endtask

  task automatic halt_idle();
    bus.halt = 1'b1;
    @(negedge clk);
    chk("halt_idle_state", int'(bus.state_o), 4);
    bus.halt = 1'b0;
    repeat (3) @(negedge clk);
    chk("halt_idle_hold", int'(bus.state_o), 4);
    clr_pulse();
  endtask

  task automatic halt_run();
    int k, r0;
    k = cyc;
    bus.run_sw = 1'b1;
    r0 = k + REACT + DIV_HALF;
    push_tick(r0);
    wait_to(r0 + 1);
    bus.halt = 1'b1;
    wait_to(r0 + DIV_HALF - 1);
    chk("halt_hi_state", int'(bus.state_o), 2);
    chk("halt_hi_clk", int'(bus.cpu_clk), 1);
    wait_to(r0 + DIV_HALF);
    chk("halted_state", int'(bus.state_o), 4);
    chk("halted_clk", int'(bus.cpu_clk), 0);
    bus.step_btn = 1'b1;
    repeat (8) @(negedge clk);
    bus.step_btn = 1'b0;
    repeat (10) @(negedge clk);
    chk("halted_ignore_step", int'(bus.state_o), 4);
    bus.halt   = 1'b0;
    bus.run_sw = 1'b0;
    repeat (10) @(negedge clk);
    chk("halted_hold", int'(bus.state_o), 4);
    chk("halted_count", int'(bus.step_count), exp_count);
    clr_pulse();
  endtask

  task automatic rst_mid_step();
    int k;
    k = cyc;
    bus.step_btn = 1'b1;
    push_tick(k + REACT);
    wait_to(k + REACT + 1);
    chk("pre_rst_clk", int'(bus.cpu_clk), 1);
    #2;
    rst = 1'b1;
    bus.step_btn = 1'b0;
    #1;
    chk("rst_clk", int'(bus.cpu_clk), 0);
    chk("rst_tick", int'(bus.cpu_tick), 0);
    chk("rst_state", int'(bus.state_o), 0);
    chk("rst_count", int'(bus.step_count), 0);
    exp_count = 0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d actual=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.run_sw   = 1'b0;
    bus.step_btn = 1'b0;
    bus.halt     = 1'b0;
    bus.clr      = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_clk", int'(bus.cpu_clk), 0);
    chk("reset_tick", int'(bus.cpu_tick), 0);
    chk("reset_state", int'(bus.state_o), 0);
    chk("reset_count", int'(bus.step_count), 0);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i % 20 == 19) begin
        chk("idle_clk", int'(bus.cpu_clk), 0);
        chk("idle_state", int'(bus.state_o), 0);
        chk("idle_count", int'(bus.step_count), 0);
      end
    end

    for (int i = 0; i < 6; i++) step_press($urandom_range(DEB_CNT, 12));
    for (int i = 0; i < 4; i++) step_press($urandom_range(1, DEB_CNT - 1));
    chk("glitch_count", int'(bus.step_count), exp_count);

    run_burst(4, 4);
    run_burst(2, 1);
    for (int i = 0; i < 4; i++) run_burst($urandom_range(1, 3), $urandom_range(0, 7));

    halt_idle();
    halt_run();

    for (int i = 0; i < 256; i++) step_press(DEB_CNT);
    chk("wrap_count", int'(bus.step_count), 0);

    rst_mid_step();
    run_burst(1, 6);

    chk("pending_ticks", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
